operand_assembler: RTL and testbench
====================================

OPERAND_ASSEMBLER -- requirements
Module: operand_assembler

Interface
REQ-001 The block SHALL take parameter NDIGITS, default 4, as the number of BCD digits per operand.
REQ-002 The block SHALL take parameter OUT_W, default 14, as the binary operand width; OUT_W >= ceil(log2(10^NDIGITS)).
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port digit_in, input, 4 bits, the current digit value 0-9 from the digit-select counter.
REQ-006 The block SHALL have port commit_pulse, input, 1 bit, a 1-cycle strobe that appends digit_in.
REQ-007 The block SHALL have port enter_pulse, input, 1 bit, a 1-cycle strobe that finishes the operand.
REQ-008 The block SHALL have port clear_pulse, input, 1 bit, a 1-cycle strobe that discards the entry.
REQ-009 The block SHALL have port bcd_out, output, 4*NDIGITS bits, the entered digits with the most recent digit in bits [3:0].
REQ-010 The block SHALL have port ndig, output, $clog2(NDIGITS+1) bits, the count of entered digits.
REQ-011 The block SHALL have port full, output, 1 bit, asserted when ndig==NDIGITS.
REQ-012 The block SHALL have port busy, output, 1 bit, asserted in CONVERT or VALID.
REQ-013 The block SHALL have port op_valid, output, 1 bit, the operand-available handshake.
REQ-014 The block SHALL have port op_ready, input, 1 bit, the consumer acceptance signal.
REQ-015 The block SHALL have port op_value, output, OUT_W bits, the unsigned binary operand.

Function
REQ-016 The FSM SHALL have states ENTRY, CONVERT and VALID.
REQ-017 In ENTRY, a commit_pulse with digit_in<=9 and full==0 SHALL shift bcd_out left 4, load digit_in into [3:0] and increment ndig.
REQ-018 Commits with digit_in>9, commits while full, and commits outside ENTRY SHALL be ignored.
REQ-019 In ENTRY, a commit of 0 while ndig==0 SHALL leave bcd_out and ndig unchanged (leading-zero suppression).
REQ-020 In ENTRY, enter_pulse SHALL move the FSM to CONVERT, clear the accumulator and point at the most significant digit.
REQ-021 Enter with ndig==0 SHALL be legal and SHALL yield op_value 0.
REQ-022 Each CONVERT cycle SHALL compute acc = (acc<<3)+(acc<<1)+digit, truncated to OUT_W, with no multiplier.
REQ-023 CONVERT SHALL last exactly NDIGITS cycles, after which the FSM enters VALID.
REQ-024 op_valid SHALL rise NDIGITS+1 cycles after the enter_pulse cycle.
REQ-025 In VALID, op_valid and op_value SHALL stay stable until op_valid && op_ready.
REQ-026 On op_valid && op_ready, the next cycle SHALL return the FSM to ENTRY with bcd_out, ndig and op_valid cleared; op_value SHALL hold its last value.
REQ-027 op_ready outside VALID SHALL be ignored.
REQ-028 clear_pulse in any state SHALL zero bcd_out and ndig, deassert op_valid and return to ENTRY on the next cycle.
REQ-029 Input priority in the same cycle SHALL be clear_pulse > enter_pulse > commit_pulse; a lower-priority strobe coincident with a higher one SHALL be dropped.

Reset
REQ-030 Reset SHALL force state ENTRY, bcd_out 0, ndig 0, full 0, busy 0, op_valid 0, op_value 0 and the accumulator 0.
REQ-031 Reset asserted mid-CONVERT or mid-VALID SHALL abort immediately, with no op_valid pulse afterwards.

Configuration
REQ-032 With OPASM_SIGN_EN defined, the block SHALL add input sign_pulse and output op_neg.
REQ-033 With OPASM_SIGN_EN, sign_pulse SHALL toggle a sign flag in ENTRY only.
REQ-034 With OPASM_SIGN_EN, the sign flag SHALL be presented on op_neg and held through VALID, and cleared by clear, handshake completion or reset.
REQ-035 Without OPASM_SIGN_EN, sign_pulse and op_neg SHALL be absent and all operands SHALL be unsigned.

Structure
REQ-036 Package opasm_pkg SHALL hold the state enum, the BCD_MAX=9 constant and the digit width constant 4.
REQ-037 The multiply-by-ten accumulate loop SHALL be the sub-module bcd_to_bin_seq, with start/done and a digit-index output.

Verification
REQ-038 Commits 1,2,3,4 then enter, op_ready=1 -> op_value=1234, op_valid high for 1 cycle, asserted 5 cycles after enter.
REQ-039 Commits 0,0,7 then enter -> ndig=1, op_value=7.
REQ-040 Five commits 9 -> full=1 after the 4th, fifth ignored; enter -> op_value=9999.
REQ-041 op_ready held 0 for 10 cycles in VALID -> op_valid and op_value stable; then ready=1 -> ENTRY, ndig=0.
REQ-042 Same-cycle clear+enter after digits 5,6 -> ENTRY, bcd_out=0, no op_valid; reset during CONVERT -> all outputs at reset values.
REQ-043 With OPASM_SIGN_EN: digits 4,2, sign_pulse, enter -> op_value=42, op_neg=1.

Source files
------------

// File: rtl/opasm_pkg.sv
// Shared types and constants for the BCD operand assembler.
package opasm_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    VALID   = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one multiply-by-ten accumulate per cycle,
// walking the digits from the most significant index down to zero.
module bcd_to_bin_seq
  import opasm_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 14,
  parameter int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DIGIT_W-1:0] digit,
  output logic [IDX_W-1:0]   digit_idx,
  output logic               done,
  output logic [OUT_W-1:0]   result
);

  localparam logic [IDX_W-1:0] MSD_IDX = IDX_W'(NDIGITS - 1);

  logic             running;
  logic [IDX_W-1:0] idx_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_nxt;

  // x10 as x8 + x2; the sum wraps at OUT_W bits.
  assign acc_nxt   = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
  assign done      = running && (idx_q == '0);
  assign result    = acc_nxt;
  assign digit_idx = idx_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      idx_q   <= MSD_IDX;
      acc_q   <= '0;
    end else if (running) begin
      acc_q <= acc_nxt;
      if (idx_q == '0) running <= 1'b0;
      else             idx_q   <= idx_q - IDX_W'(1);
    end
  end

endmodule

// File: rtl/operand_assembler.sv
// Collects BCD digits from a keypad strobe, converts them to binary and offers
// the result on a valid/ready handshake. Define OPASM_SIGN_EN for a sign flag.
module operand_assembler
  import opasm_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int OUT_W   = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DIGIT_W-1:0]           digit_in,
  input  logic                         commit_pulse,
  input  logic                         enter_pulse,
  input  logic                         clear_pulse,
  output logic [DIGIT_W*NDIGITS-1:0]   bcd_out,
  output logic [$clog2(NDIGITS+1)-1:0] ndig,
  output logic                         full,
  output logic                         busy,
  output logic                         op_valid,
  input  logic                         op_ready,
`ifdef OPASM_SIGN_EN
  input  logic                         sign_pulse,
  output logic                         op_neg,
`endif
  output logic [OUT_W-1:0]             op_value
);

  localparam int NDIG_W = $clog2(NDIGITS + 1);
  localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int BCD_W  = DIGIT_W * NDIGITS;

  state_t state, state_nxt;

  logic [BCD_W-1:0]   bcd_q;
  logic [NDIG_W-1:0]  ndig_q;
  logic [OUT_W-1:0]   op_value_q;
  logic               is_full;
  logic               handshake;
  logic               commit_ok;
  logic               conv_start;
  logic               conv_done;
  logic [IDX_W-1:0]   conv_idx;
  logic [DIGIT_W-1:0] conv_digit;
  logic [OUT_W-1:0]   conv_result;

  assign is_full    = (ndig_q == NDIG_W'(NDIGITS));
  assign handshake  = (state == VALID) && op_ready;
  assign conv_start = (state == ENTRY) && enter_pulse && !clear_pulse;

  // Strobe priority is clear > enter > commit; a leading zero is not a digit.
  assign commit_ok = (state == ENTRY) && commit_pulse && !clear_pulse && !enter_pulse
                  && (digit_in <= BCD_MAX) && !is_full
                  && !((digit_in == '0) && (ndig_q == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ENTRY;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    if (clear_pulse) begin
      state_nxt = ENTRY;
    end else begin
      case (state)
        ENTRY:   if (enter_pulse) state_nxt = CONVERT;
        CONVERT: if (conv_done)   state_nxt = VALID;
        VALID:   if (op_ready)    state_nxt = ENTRY;
        default:                  state_nxt = ENTRY;
      endcase
    end
  end

  always_comb begin
    op_valid = (state == VALID);
    busy     = (state == CONVERT) || (state == VALID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q  <= '0;
      ndig_q <= '0;
    end else if (clear_pulse || handshake) begin
      bcd_q  <= '0;
      ndig_q <= '0;
    end else if (commit_ok) begin
      bcd_q  <= (bcd_q << DIGIT_W) | BCD_W'(digit_in);
      ndig_q <= ndig_q + NDIG_W'(1);
    end
  end

  // op_value only changes when a conversion completes, so it survives the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                   op_value_q <= '0;
    else if ((state == CONVERT) && conv_done && !clear_pulse)    op_value_q <= conv_result;
  end

  always_comb begin
    conv_digit = '0;
    for (int i = 0; i < NDIGITS; i++)
      if (conv_idx == IDX_W'(i)) conv_digit = bcd_q[i*DIGIT_W +: DIGIT_W];
  end

  bcd_to_bin_seq #(
    .NDIGITS (NDIGITS),
    .OUT_W   (OUT_W),
    .IDX_W   (IDX_W)
  ) u_conv (
    .clk       (clk),
    .reset     (reset),
    .start     (conv_start),
    .abort     (clear_pulse),
    .digit     (conv_digit),
    .digit_idx (conv_idx),
    .done      (conv_done),
    .result    (conv_result)
  );

  assign bcd_out  = bcd_q;
  assign ndig     = ndig_q;
  assign full     = is_full;
  assign op_value = op_value_q;

`ifdef OPASM_SIGN_EN
  logic sign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  sign_q <= 1'b0;
    else if (clear_pulse || handshake)          sign_q <= 1'b0;
    else if ((state == ENTRY) && sign_pulse)    sign_q <= ~sign_q;
  end

  assign op_neg = sign_q;
`endif

endmodule

// File: tb/tb_operand_assembler.sv
// Self-checking bench for operand_assembler: directed scenarios plus random
// strobes, all compared against a digit-queue reference model.
module tb_operand_assembler;

  localparam int NDIGITS = 4;
  localparam int OUT_W   = 14;
  localparam int NDIG_W  = $clog2(NDIGITS + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [3:0]             digit_in;
  logic                   commit_pulse, enter_pulse, clear_pulse, op_ready;
  logic [4*NDIGITS-1:0]   bcd_out;
  logic [NDIG_W-1:0]      ndig;
  logic                   full, busy, op_valid;
  logic [OUT_W-1:0]       op_value;
`ifdef OPASM_SIGN_EN
  logic                   sign_pulse;
  logic                   op_neg;
`endif

  always #5 clk = ~clk;

  operand_assembler #(.NDIGITS(NDIGITS), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_in     (digit_in),
    .commit_pulse (commit_pulse),
    .enter_pulse  (enter_pulse),
    .clear_pulse  (clear_pulse),
    .bcd_out      (bcd_out),
    .ndig         (ndig),
    .full         (full),
    .busy         (busy),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
`ifdef OPASM_SIGN_EN
    .sign_pulse   (sign_pulse),
    .op_neg       (op_neg),
`endif
    .op_value     (op_value)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the operand as a queue of decimal digits, oldest first.
  int m_digits[$];
  bit m_conv, m_valid, m_neg;
  int m_left, m_pending, m_value;

  function automatic void model_reset();
    m_digits.delete();
    m_conv = 0; m_valid = 0; m_neg = 0;
    m_left = 0; m_pending = 0; m_value = 0;
  endfunction

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v % (1 << OUT_W);
  endfunction

  function automatic logic [4*NDIGITS-1:0] digits_bcd();
    logic [4*NDIGITS-1:0] v = '0;
    foreach (m_digits[i]) v = (v << 4) | (4*NDIGITS)'(m_digits[i]);
    return v;
  endfunction

  function automatic void model_step(bit clr, bit ent, bit com, int d, bit rdy, bit sgn);
    if (clr) begin
      m_digits.delete();
      m_conv = 0; m_valid = 0; m_neg = 0;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        m_digits.delete();
        m_neg = 0;
      end
    end else if (m_conv) begin
      m_left--;
      if (m_left == 0) begin
        m_conv  = 0;
        m_valid = 1;
        m_value = m_pending;
      end
    end else begin
      if (sgn) m_neg = !m_neg;
      if (ent) begin
        m_conv    = 1;
        m_left    = NDIGITS;
        m_pending = digits_value();
      end else if (com && d <= 9 && m_digits.size() < NDIGITS
                   && !(d == 0 && m_digits.size() == 0)) begin
        m_digits.push_back(d);
      end
    end
  endfunction

  task automatic check_outputs();
    check("bcd_out",  bcd_out,  digits_bcd());
    check("ndig",     ndig,     m_digits.size());
    check("full",     full,     m_digits.size() == NDIGITS);
    check("busy",     busy,     m_conv || m_valid);
    check("op_valid", op_valid, m_valid);
    check("op_value", op_value, m_value);
`ifdef OPASM_SIGN_EN
    check("op_neg",   op_neg,   m_neg);
`endif
  endtask

  task automatic step(input bit clr, input bit ent, input bit com, input int d,
                      input bit rdy, input bit sgn);
    @(negedge clk);
    clear_pulse  = clr;
    enter_pulse  = ent;
    commit_pulse = com;
    digit_in     = 4'(d);
    op_ready     = rdy;
`ifdef OPASM_SIGN_EN
    sign_pulse   = sgn;
`endif
    @(posedge clk);
    model_step(clr, ent, com, d, rdy, sgn);
    #1;
    check_outputs();
  endtask

  task automatic commit(input int d);
    step(0, 0, 1, d, 0, 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, rdy, 0);
  endtask

  task automatic enter_and_wait(input string tag);
    int n;
    step(0, 1, 0, 0, 0, 0);
    n = 1;
    while (!op_valid && n < 20) begin
      idle(0);
      n++;
    end
    check({tag, "_latency"}, n, NDIGITS + 1);
  endtask

  initial begin
    reset = 1'b1;
    digit_in = '0; commit_pulse = 0; enter_pulse = 0; clear_pulse = 0; op_ready = 0;
`ifdef OPASM_SIGN_EN
    sign_pulse = 0;
`endif
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // 1,2,3,4 then enter with ready held high: one-cycle valid after 5 edges.
    begin
      int n;
      commit(1); commit(2); commit(3); commit(4);
      step(0, 1, 0, 0, 1, 0);
      n = 1;
      while (!op_valid && n < 20) begin
        step(0, 0, 0, 0, 1, 0);
        n++;
      end
      check("a_latency", n, NDIGITS + 1);
      check("a_value", op_value, 1234);
      step(0, 0, 0, 0, 1, 0);
      check("a_pulse_len", op_valid, 0);
      check("a_ndig_cleared", ndig, 0);
      check("a_value_held", op_value, 1234);
    end

    // Leading zeros are suppressed.
    commit(0); commit(0); commit(7);
    check("b_ndig", ndig, 1);
    enter_and_wait("b");
    check("b_value", op_value, 7);
    idle(1);

    // Fifth digit is dropped once full.
    for (int i = 0; i < 4; i++) commit(9);
    check("c_full", full, 1);
    commit(9);
    check("c_ndig", ndig, 4);
    enter_and_wait("c");
    check("c_value", op_value, 9999);
    idle(1);

    // Consumer stalls for ten cycles, then accepts.
    commit(3); commit(0); commit(5);
    enter_and_wait("d");
    for (int i = 0; i < 10; i++) begin
      idle(0);
      check("d_valid_stall", op_valid, 1);
      check("d_value_stall", op_value, 305);
    end
    idle(1);
    check("d_ndig_after", ndig, 0);
    check("d_busy_after", busy, 0);

    // Clear coincident with enter wins; no operand appears.
    commit(5); commit(6);
    step(1, 1, 0, 0, 0, 0);
    check("e_bcd", bcd_out, 0);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check("e_no_valid", op_valid, 0);
    end

    // Enter with no digits yields zero.
    enter_and_wait("z");
    check("z_value", op_value, 0);
    idle(1);

    // Asynchronous reset in the middle of a conversion.
    commit(8); commit(1);
    enter_and_wait("f_pre");
    idle(1);
    commit(6); commit(2);
    step(0, 1, 0, 0, 0, 0);
    idle(0); idle(0);
    reset = 1'b1;
    model_reset();
    #2;
    check("f_busy", busy, 0);
    check("f_value", op_value, 0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check("f_no_valid", op_valid, 0);
    end

`ifdef OPASM_SIGN_EN
    commit(4); commit(2);
    step(0, 0, 0, 0, 0, 1);
    enter_and_wait("g");
    check("g_value", op_value, 42);
    check("g_neg", op_neg, 1);
    idle(1);
    check("g_neg_cleared", op_neg, 0);
`endif

    // Random strobes, including coincident ones and out-of-range digits.
    for (int i = 0; i < 600; i++) begin
      int r, d;
      bit clr, ent, com, rdy, sgn;
      r   = int'($urandom_range(0, 99));
      clr = (r < 3);
      ent = (r >= 3 && r < 11) || ($urandom_range(0, 24) == 0);
      com = ($urandom_range(0, 1) == 1);
      d   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                         : int'($urandom_range(0, 9));
      rdy = ($urandom_range(0, 2) != 0);
      sgn = ($urandom_range(0, 7) == 0);
      step(clr, ent, com, d, rdy, sgn);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
